// File: rtl/ps2_rx_deserializer.sv
// -----------------------------------------------------------------------------
// ps2_rx_deserializer
//   PS/2 device-to-host receiver. The raw PS/2 clock and data lines are
//   synchronized into the i_clk domain. The PS/2 clock is deglitched by a
//   run-length filter, and 11-bit frames are deserialized from it:
//   start(0), 8 data bits LSB first, odd parity, stop(1).
//   Each good byte is presented on o_code with a one-cycle o_code_DV strobe.
//   Dropped frames raise a one-cycle o_parity_err or o_frame_err strobe.
//
//   Optional feature macro: PS2_RX_TIMEOUT_EN
//     When defined, a frame that stalls for TIMEOUT_CYCLES i_clk cycles
//     without a PS/2 falling edge is aborted with an o_frame_err pulse.
//     When undefined, a partial frame waits indefinitely.
//
// Parameters
//   SYNC_STAGES    synchronizer depth on both PS/2 lines (>= 2)
//   FILTER_LEN     equal consecutive samples needed to flip the filtered clock
//   TIMEOUT_CYCLES stall limit used only with PS2_RX_TIMEOUT_EN
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_ps2_clk      raw PS/2 clock line (asynchronous)
//   i_ps2_data     raw PS/2 data line (asynchronous)
//   o_code         last good byte, held until the next good byte
//   o_code_DV      one-cycle strobe: o_code updated this cycle
//   o_parity_err   one-cycle strobe: frame dropped on a parity failure
//   o_frame_err    one-cycle strobe: frame dropped on a bad stop bit or timeout
// -----------------------------------------------------------------------------
module ps2_rx_deserializer #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_code,
    output logic       o_code_DV,
    output logic       o_parity_err,
    output logic       o_frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic [FILTER_LEN-1:0]  hist_r;
    logic                   filt_r;
    logic                   filt_d_r;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_s;
    logic                   tmo_abort_s;

    state_t     state_r, state_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] shift_r, shift_s;
    logic       par_r, par_s;
    logic [7:0] code_r, code_s;
    logic       dv_r, dv_s;
    logic       perr_r, perr_s;
    logic       ferr_r, ferr_s;

    assign clk_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_s = data_sync_r[SYNC_STAGES-1];
    // A sample event is the filtered clock having been high last cycle and low now.
    assign fall_s = filt_d_r & ~filt_r;

    // Synchronizer chains for both asynchronous PS/2 lines (idle level is high).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    // Run-length deglitch filter on the synchronized PS/2 clock plus edge-detect delay.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_r   <= {FILTER_LEN{1'b1}};
            filt_r   <= 1'b1;
            filt_d_r <= 1'b1;
        end else begin
            hist_r   <= {hist_r[FILTER_LEN-2:0], clk_s};
            filt_d_r <= filt_r;
            if (hist_r == {FILTER_LEN{1'b0}}) begin
                filt_r <= 1'b0;
            end else if (hist_r == {FILTER_LEN{1'b1}}) begin
                filt_r <= 1'b1;
            end else begin
                filt_r <= filt_r;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] tmo_cnt_r;

    // A sample event on the limit cycle wins over the timeout.
    assign tmo_abort_s = ~fall_s & (state_r != ST_IDLE) & (tmo_cnt_r == TMO_LAST);

    // Stall counter: runs only while a frame is in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (fall_s || (state_r == ST_IDLE) || tmo_abort_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end
    end
`else
    logic unused_timeout_s;

    assign tmo_abort_s      = 1'b0;
    // Keeps the stall-limit parameter referenced when the feature is compiled out.
    assign unused_timeout_s = (TIMEOUT_CYCLES > 32'sd0);
`endif

    // Frame FSM next-state and output decode; advances only on sample events.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        par_s     = par_r;
        code_s    = code_r;
        dv_s      = 1'b0;
        perr_s    = 1'b0;
        ferr_s    = 1'b0;
        if (tmo_abort_s) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 3'd0;
            shift_s   = 8'h00;
            ferr_s    = 1'b1;
        end else if (fall_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_s   = ST_DATA;
                        bit_cnt_s = 3'd0;
                        shift_s   = 8'h00;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_s[bit_cnt_r] = data_s;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_PARITY;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_s   = data_s;
                    state_s = ST_STOP;
                end
                ST_STOP: begin
                    state_s = ST_IDLE;
                    if (!data_s) begin
                        ferr_s = 1'b1;
                    end else if (^{shift_r, par_r}) begin
                        code_s = shift_r;
                        dv_s   = 1'b1;
                    end else begin
                        perr_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, datapath and registered output strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
            code_r    <= 8'h00;
            dv_r      <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            par_r     <= par_s;
            code_r    <= code_s;
            dv_r      <= dv_s;
            perr_r    <= perr_s;
            ferr_r    <= ferr_s;
        end
    end

    assign o_code       = code_r;
    assign o_code_DV    = dv_r;
    assign o_parity_err = perr_r;
    assign o_frame_err  = ferr_r;

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx_deserializer
//   Drives PS/2 frames (directed cases plus $urandom frames with injected
//   parity/stop errors and clock glitches) and checks the receiver against a
//   frame-level model: every frame the bench sends predicts one outcome
//   (good byte / parity error / frame error) that must appear within a cycle
//   window, and o_code must always equal the last good byte the model sent.
//   PS/2 timing is scaled down (half period HALF i_clk cycles) to keep the run
//   short; the stall limit is overridden to TMO cycles.
// -----------------------------------------------------------------------------
module tb_ps2_rx_deserializer;

    localparam int HALF = 40;
    localparam int TMO  = 600;
    localparam int WIN  = 40;

    localparam int K_DV   = 0;
    localparam int K_PERR = 1;
    localparam int K_FERR = 2;

    logic       i_clk      = 1'b0;
    logic       i_rst_n    = 1'b0;
    logic       i_ps2_clk  = 1'b1;
    logic       i_ps2_data = 1'b1;
    logic [7:0] o_code;
    logic       o_code_DV;
    logic       o_parity_err;
    logic       o_frame_err;

    ps2_rx_deserializer #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_data  (i_ps2_data),
        .o_code      (o_code),
        .o_code_DV   (o_code_DV),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err)
    );

    always #10 i_clk = ~i_clk;

    typedef struct {
        int         kind;
        logic [7:0] code;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       q[$];
    logic [7:0] committed = 8'h00;
    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         edge_cyc  = 0;
    int         dv_seen   = 0;
    int         perr_seen = 0;
    int         ferr_seen = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Compare process: strobes against predicted outcomes, o_code against the model.
    always @(negedge i_clk) begin
        int   n;
        int   kind;
        exp_t e;
        if (!i_rst_n) begin
            checks++;
            if (o_code !== 8'h00 || o_code_DV !== 1'b0 || o_parity_err !== 1'b0 || o_frame_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_state got code=%h dv=%b perr=%b ferr=%b want code=00 strobes=0",
                         o_code, o_code_DV, o_parity_err, o_frame_err);
            end
        end else begin
            n    = int'(o_code_DV) + int'(o_parity_err) + int'(o_frame_err);
            kind = o_code_DV ? K_DV : (o_parity_err ? K_PERR : K_FERR);
            if (n > 1) begin
                failures++;
                $display("FAIL strobe_exclusive got dv=%b perr=%b ferr=%b want at most one",
                         o_code_DV, o_parity_err, o_frame_err);
            end
            if (n >= 1) begin
                if (kind == K_DV) dv_seen++;
                else if (kind == K_PERR) perr_seen++;
                else ferr_seen++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe got kind=%0d at cycle %0d want no strobe", kind, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.kind != kind || cyc < e.lo || cyc > e.hi) begin
                        failures++;
                        $display("FAIL strobe_kind got kind=%0d cycle=%0d want kind=%0d in [%0d,%0d]",
                                 kind, cyc, e.kind, e.lo, e.hi);
                    end
                    if (kind == K_DV) begin
                        checks++;
                        if (o_code !== e.code) begin
                            failures++;
                            $display("FAIL dv_code got %h want %h", o_code, e.code);
                        end
                    end
                    if (e.kind == K_DV) committed = e.code;
                end
            end else if (q.size() > 0 && cyc > q[0].hi) begin
                checks++;
                failures++;
                $display("FAIL missing_strobe got none by cycle %0d want kind=%0d", cyc, q[0].kind);
                void'(q.pop_front());
            end
            checks++;
            if (o_code !== committed) begin
                failures++;
                $display("FAIL code_hold got %h want %h at cycle %0d", o_code, committed, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    // Clock-high phase with data set up; optional low glitch in the middle.
    task automatic ps2_high(input logic b, input int glitch);
        i_ps2_data = b;
        if (glitch > 0) begin
            tick(HALF / 2);
            i_ps2_clk = 1'b0;
            tick(glitch);
            i_ps2_clk = 1'b1;
            tick(HALF - HALF / 2 - glitch);
        end else begin
            tick(HALF);
        end
    endtask

    task automatic ps2_fall();
        i_ps2_clk = 1'b0;
        edge_cyc  = cyc;
    endtask

    task automatic ps2_rise();
        tick(HALF);
        i_ps2_clk = 1'b1;
    endtask

    task automatic expect_outcome(input int kind, input logic [7:0] code, input int lo, input int hi);
        exp_t e;
        e.kind = kind;
        e.code = code;
        e.lo   = lo;
        e.hi   = hi;
        q.push_back(e);
    endtask

    // Full 11-bit frame; the model decides the outcome from the stop and parity rules.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int glitch_bit, input int glitch_len, input int pause);
        logic [10:0] f;
        int          kind;
        f = {stp, par, b, 1'b0};
        if (!stp) kind = K_FERR;
        else if ((^b) ^ par) kind = K_DV;
        else kind = K_PERR;
        for (int i = 0; i < 11; i++) begin
            ps2_high(f[i], (i == glitch_bit) ? glitch_len : 0);
            ps2_fall();
            if (i == 10) expect_outcome(kind, b, edge_cyc + 1, edge_cyc + WIN);
            ps2_rise();
            if (i == 4 && pause > 0) tick(pause);
        end
        i_ps2_data = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1, -1, 0, 0);
    endtask

    task automatic pin(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       rp;
        logic       rs;
        int         r;
        int         gb;
        int         gl;

        tick(5);
        i_rst_n = 1'b1;
        tick(20);

        // 1: single good frame
        send_frame(8'h1D, 1'b1, 1'b1, -1, 0, 0);
        tick(60);
        pin("t1_code", int'(o_code), 32'h1D);
        pin("t1_dv_count", dv_seen, 1);

        // 2: back-to-back frames
        send_frame(8'hF0, 1'b1, 1'b1, -1, 0, 0);
        send_frame(8'h1C, 1'b0, 1'b1, -1, 0, 0);
        tick(60);
        pin("t2_code", int'(o_code), 32'h1C);
        pin("t2_dv_count", dv_seen, 3);

        // 3: parity error keeps the previous byte
        send_frame(8'h1C, 1'b1, 1'b1, -1, 0, 0);
        tick(60);
        pin("t3_perr_count", perr_seen, 1);
        pin("t3_code_kept", int'(o_code), 32'h1C);

        // 4: bad stop bit, then a good frame
        send_frame(8'h23, 1'b0, 1'b0, -1, 0, 0);
        tick(60);
        pin("t4_ferr_count", ferr_seen, 1);
        send_frame(8'h29, 1'b0, 1'b1, -1, 0, 0);
        tick(60);
        pin("t4_code", int'(o_code), 32'h29);

        // 5: glitches while idle and mid-frame
        tick(10);
        i_ps2_clk = 1'b0;
        tick(3);
        i_ps2_clk = 1'b1;
        tick(30);
        send_frame(8'h1B, 1'b1, 1'b1, 5, 3, 0);
        tick(60);
        pin("t5_code", int'(o_code), 32'h1B);
        pin("t5_dv_count", dv_seen, 5);

`ifdef PS2_RX_TIMEOUT_EN
        // 6: stalled partial frame aborts after the stall limit
        for (int i = 0; i < 5; i++) begin
            ps2_high((i == 0) ? 1'b0 : 1'b1, 0);
            ps2_fall();
            if (i == 4) expect_outcome(K_FERR, 8'h00, edge_cyc + TMO, edge_cyc + TMO + WIN);
            ps2_rise();
        end
        i_ps2_data = 1'b1;
        tick(TMO + 100);
        pin("t6_timeout_ferr", ferr_seen, 2);
        good_frame(8'h76);
        tick(60);
        pin("t6_code", int'(o_code), 32'h76);
`else
        // Stalled partial frame simply resumes when edges return
        send_frame(8'h5A, 1'b1, 1'b1, -1, 0, 1500);
        tick(60);
        pin("stall_resume_code", int'(o_code), 32'h5A);
        pin("stall_no_ferr", ferr_seen, 1);
`endif

        // Reset in the middle of a frame discards it
        for (int i = 0; i < 3; i++) begin
            ps2_high((i == 0) ? 1'b0 : 1'b1, 0);
            ps2_fall();
            ps2_rise();
        end
        i_rst_n = 1'b0;
        q.delete();
        committed  = 8'h00;
        i_ps2_data = 1'b1;
        tick(3);
        i_rst_n = 1'b1;
        tick(20);
        pin("midreset_code", int'(o_code), 32'h00);
        good_frame(8'h14);
        tick(60);
        pin("post_reset_code", int'(o_code), 32'h14);

        // Randomized frames with injected errors, glitches and random gaps
        for (int k = 0; k < 25; k++) begin
            rb = 8'($urandom);
            rp = ~^rb;
            rs = 1'b1;
            r  = int'($urandom_range(0, 99));
            if (r < 12) rp = ~rp;
            else if (r < 20) rs = 1'b0;
            gb = -1;
            gl = 0;
            if ($urandom_range(0, 3) == 0) begin
                gb = int'($urandom_range(0, 10));
                gl = int'($urandom_range(1, 6));
            end
            send_frame(rb, rp, rs, gb, gl, 0);
            if ($urandom_range(0, 1) == 1) tick(int'($urandom_range(0, 100)));
        end

        tick(100);
        pin("pending_outcomes", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
